// File: rtl/tree_pkg.sv
// Shared constants and helpers for the pipelined adder tree.
package tree_pkg;

  localparam int TREE_DW   = 10;
  localparam int TREE_N_IN = 8;

  // One register level per halving of the operand count.
  function automatic int tree_levels(input int n);
    return $clog2(n);
  endfunction

  function automatic int tree_sat_max(input int dw);
    return (1 << dw) - 1;
  endfunction

  localparam int TREE_SAT_MAX = tree_sat_max(TREE_DW);

endpackage

// File: rtl/tree_add_node.sv
// Registered two-input unsigned adder; result is one bit wider than its operands.
module tree_add_node
  import tree_pkg::*;
#(
  parameter int W = TREE_DW
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W:0]   sum
);

  always_ff @(posedge clk) begin
    if (rst)
      sum <= '0;
    else if (en)
      sum <= {1'b0, a} + {1'b0, b};
  end

endmodule

// File: rtl/tree_add_pipe.sv
// Pipelined unsigned adder tree with global stall, saturating output and
// an overflow event counter.
module tree_add_pipe
  import tree_pkg::*;
#(
  parameter int DW   = TREE_DW,
  parameter int N_IN = TREE_N_IN,
  parameter int SAT  = 1,
  parameter int SCW  = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [N_IN*DW-1:0] in_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [DW-1:0]      out_data,
  output logic               out_sat,
  output logic [SCW-1:0]     sat_count
);

  localparam int L = tree_levels(N_IN);
  localparam logic [DW-1:0] SAT_MAX = DW'(tree_sat_max(DW));

  generate
    if (N_IN < 2 || N_IN > 16 || (N_IN & (N_IN - 1)) != 0) begin : g_bad_n_in
      $error("tree_add_pipe: N_IN must be a power of 2 in 2..16");
    end
  endgenerate

  // Bit offset of level j inside the flat partial-sum vector.
  function automatic int lvl_off(input int j);
    int o;
    o = 0;
    for (int i = 0; i < j; i++)
      o += (N_IN >> i) * (DW + i);
    return o;
  endfunction

  localparam int TOT = lvl_off(L + 1);

  function automatic logic [DW-1:0] sat_wrap(input logic [DW+L-1:0] s);
    if (SAT != 0 && (|s[DW+L-1:DW]))
      return SAT_MAX;
    return s[DW-1:0];
  endfunction

  logic [TOT-1:0] lvl;
  logic [L:1]     vld_p;
  logic           adv;
  logic [DW+L-1:0] sum_full;

  assign adv       = out_ready | ~vld_p[L];
  assign in_ready  = adv;
  assign out_valid = vld_p[L];

  assign lvl[N_IN*DW-1:0] = in_data;

  // Level j pairs adjacent sums of level j-1; all levels advance together on adv.
  generate
    for (genvar j = 1; j <= L; j++) begin : g_lvl
      for (genvar k = 0; k < (N_IN >> j); k++) begin : g_node
        tree_add_node #(
          .W(DW + j - 1)
        ) u_node (
          .clk(clk),
          .rst(rst),
          .en (adv),
          .a  (lvl[lvl_off(j-1) + (2*k)   * (DW+j-1) +: DW+j-1]),
          .b  (lvl[lvl_off(j-1) + (2*k+1) * (DW+j-1) +: DW+j-1]),
          .sum(lvl[lvl_off(j)   + k       * (DW+j)   +: DW+j])
        );
      end
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p <= '0;
    end else if (adv) begin
      vld_p[1] <= in_valid;
      for (int j = 2; j <= L; j++)
        vld_p[j] <= vld_p[j-1];
    end
  end

  // Output stage: level L register viewed through the saturate/wrap mux.
  assign sum_full = lvl[lvl_off(L) +: DW+L];
  assign out_sat  = |sum_full[DW+L-1:DW];
  assign out_data = sat_wrap(sum_full);

  always_ff @(posedge clk) begin
    if (rst)
      sat_count <= '0;
    else if (out_valid && out_ready && out_sat && (sat_count != '1))
      sat_count <= sat_count + 1'b1;
  end

endmodule

// File: tb/tb_tree_add_pipe.sv
// Directed bench for tree_add_pipe: three instances (SAT=1, SAT=0, SCW=4) share stimulus.
module tb_tree_add_pipe;

  localparam int DW = 10;
  localparam int N  = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic in_valid = 1'b0;
  logic out_ready = 1'b1;
  logic [N*DW-1:0] in_data = '0;

  logic ir0, ov0, os0, ir1, ov1, os1, ir2, ov2, os2;
  logic [DW-1:0] od0, od1, od2;
  logic [15:0] sc0, sc1;
  logic [3:0]  sc2;

  tree_add_pipe #(.DW(DW), .N_IN(N), .SAT(1), .SCW(16)) dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir0), .in_data(in_data),
    .out_valid(ov0), .out_ready(out_ready), .out_data(od0), .out_sat(os0), .sat_count(sc0));
  tree_add_pipe #(.DW(DW), .N_IN(N), .SAT(0), .SCW(16)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir1), .in_data(in_data),
    .out_valid(ov1), .out_ready(out_ready), .out_data(od1), .out_sat(os1), .sat_count(sc1));
  tree_add_pipe #(.DW(DW), .N_IN(N), .SAT(1), .SCW(4)) dut2 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir2), .in_data(in_data),
    .out_valid(ov2), .out_ready(out_ready), .out_data(od2), .out_sat(os2), .sat_count(sc2));

  always #5 clk = ~clk;

  int total = 0;
  int passed = 0;
  int fails = 0;
  int q[$];
  int m0 = 0;
  int m2 = 0;
  int n_out = 0;
  bit armed = 0;
  bit stall_prev = 0;
  logic [DW-1:0] prev_data;
  logic prev_sat;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int vsum(input logic [N*DW-1:0] v);
    int s;
    s = 0;
    for (int k = 0; k < N; k++) s += int'(v[k*DW +: DW]);
    return s;
  endfunction

  function automatic logic [N*DW-1:0] ramp(input int base, input int stp);
    logic [N*DW-1:0] v;
    for (int k = 0; k < N; k++) v[k*DW +: DW] = DW'(base + k * stp);
    return v;
  endfunction

  function automatic logic [N*DW-1:0] rvec(input int lo, input int hi);
    logic [N*DW-1:0] v;
    for (int k = 0; k < N; k++) v[k*DW +: DW] = DW'($urandom_range(hi, lo));
    return v;
  endfunction

  // One clock cycle: drive inputs, record acceptance at the falling edge.
  task automatic step(input logic v, input logic [N*DW-1:0] d, input logic rdy,
                      input logic r, output bit acc);
    in_valid = v; in_data = d; out_ready = rdy; rst = r;
    @(negedge clk);
    acc = (v === 1'b1) && (ir0 === 1'b1) && (r === 1'b0);
    if (acc) q.push_back(vsum(d));
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    bit a;
    for (int i = 0; i < n; i++) step(1'b0, '0, 1'b1, 1'b0, a);
  endtask

  // Called right after the accepting step; out_valid must rise on the third level.
  task automatic latency(input string tag);
    bit a;
    for (int k = 1; k <= 4; k++) begin
      check(tag, ov0, (k == 3));
      step(1'b0, '0, 1'b1, 1'b0, a);
    end
  endtask

  // Scoreboard / monitor
  always @(negedge clk) begin
    if (armed) begin
      if (rst) begin
        q.delete();
        m0 = 0; m2 = 0; stall_prev = 0;
      end else begin
        check("in_ready", ir0, !(ov0 && !out_ready));
        check("sat_count_16", sc0, m0);
        check("sat_count_sat0", sc1, m0);
        check("sat_count_4", sc2, m2);
        if (stall_prev) begin
          check("stall_valid", ov0, 1);
          check("stall_data", od0, prev_data);
          check("stall_sat", os0, prev_sat);
        end
        if (ov0 && out_ready) begin
          check("out_expected", (q.size() != 0), 1);
          if (q.size() != 0) begin
            int s;
            s = q.pop_front();
            check("data_sat1", od0, (s > 1023) ? 1023 : s);
            check("flag_sat1", os0, (s > 1023));
            check("data_sat0", od1, s & 1023);
            check("flag_sat0", os1, (s > 1023));
            check("data_scw4", od2, (s > 1023) ? 1023 : s);
            if (s > 1023) begin
              m0++;
              if (m2 < 15) m2++;
            end
            n_out++;
          end
        end
        stall_prev = ov0 && !out_ready;
        prev_data  = od0;
        prev_sat   = os0;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    bit a;
    int idx, c, stalls, nb;
    logic [N*DW-1:0] v;

    // Reset with random inputs
    for (int i = 0; i < 3; i++) begin
      step(1'($urandom_range(1, 0)), rvec(0, 1023), 1'($urandom_range(1, 0)), 1'b1, a);
      armed = 1;
      check("rst_valid", ov0, 0);
      check("rst_data", od0, 0);
      check("rst_sat", os0, 0);
      check("rst_count", sc0, 0);
      check("rst_ready", ir0, 1);
    end
    step(1'b0, '0, 1'b1, 1'b0, a);

    // Single vector 1..8
    step(1'b1, ramp(1, 1), 1'b1, 1'b0, a);
    check("t2_accept", a, 1);
    latency("t2_latency");

    // Overflow, all operands 1023
    step(1'b1, ramp(1023, 0), 1'b1, 1'b0, a);
    check("t3_accept", a, 1);
    latency("t3_latency");
    check("t3_count", sc0, 1);
    check("t3_count_sat0", sc1, 1);

    // Boundary: sum exactly 1023, then 1024
    v = ramp(127, 0); v[7*DW +: DW] = 10'd134;
    step(1'b1, v, 1'b1, 1'b0, a);
    v[7*DW +: DW] = 10'd135;
    step(1'b1, v, 1'b1, 1'b0, a);
    idle(5);
    check("bnd_count", sc0, 2);

    // Back-pressure stream of 10 vectors
    idx = 1; c = 0; stalls = 0; nb = n_out;
    while (idx <= 10 && c < 60) begin
      step(1'b1, ramp(idx, 0), !(c >= 4 && c <= 8), 1'b0, a);
      if (a) idx++;
      else stalls++;
      c++;
    end
    check("t4_all_accepted", idx, 11);
    check("t4_stall_seen", (stalls > 0), 1);
    idle(6);
    check("t4_drained", q.size(), 0);
    check("t4_count", n_out - nb, 10);

    // Reset mid-flight
    step(1'b1, ramp(5, 0), 1'b1, 1'b0, a);
    step(1'b1, ramp(6, 0), 1'b1, 1'b0, a);
    step(1'b0, '0, 1'b1, 1'b1, a);
    nb = n_out;
    for (int i = 0; i < 4; i++) begin
      check("t5_no_valid", ov0, 0);
      step(1'b0, '0, 1'b1, 1'b0, a);
    end
    check("t5_none_emitted", n_out - nb, 0);
    check("t5_count_cleared", sc0, 0);
    step(1'b1, ramp(2, 0), 1'b1, 1'b0, a);
    check("t5_accept", a, 1);
    latency("t5_latency");

    // Counter saturation on the 4-bit instance
    step(1'b0, '0, 1'b1, 1'b1, a);
    for (int i = 0; i < 20; i++) begin
      step(1'b1, rvec(600, 1023), 1'b1, 1'b0, a);
      check("t6_accept", a, 1);
    end
    for (int i = 0; i < 3; i++) step(1'b1, rvec(0, 127), 1'b1, 1'b0, a);
    idle(6);
    check("t6_count4", sc2, 15);
    check("t6_count16", sc0, 20);
    check("final_drained", q.size(), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
